tdm_demux16: RTL and testbench

- Receive end of the 16-lane time-division link: a 16:1 mux serialises lanes onto one wire, and this block reconstructs the 16 lanes.
- Takes a serial bit stream (one lane bit per valid beat) plus a frame-sync marker on lane 0.
- Tracks the lane index with a counter and steers each bit to its lane.
- Outputs live per-lane values and a completed 16-bit frame with a one-cycle valid pulse.

---
 rtl/tdm_pkg.sv | 13 +
 rtl/tdm_ch_counter.sv | 44 ++++
 rtl/tdm_demux16.sv | 115 +++++++++++
 tb/tb_tdm_demux16.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared defaults and types for the 16-lane TDM receive path.
package tdm_pkg;

  localparam int unsigned N_CH_DEF  = 16;
  localparam int unsigned SEL_W_DEF = 4;
  localparam int unsigned LAST_CH   = N_CH_DEF - 1;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_e;

endpackage

// File: rtl/tdm_ch_counter.sv
// Lane-index counter: rst > clr > load1 > inc, wrapping LAST_CH -> 0.
module tdm_ch_counter
  import tdm_pkg::*;
#(
  parameter int unsigned SEL_W  = SEL_W_DEF,
  parameter int unsigned LAST_P = LAST_CH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load1,
  input  logic             clr,
  output logic [SEL_W-1:0] cnt,
  output logic             at_last
);

  localparam logic [SEL_W-1:0] LAST_V = LAST_P[SEL_W-1:0];

  logic [SEL_W-1:0] cnt_q;
  logic [SEL_W-1:0] cnt_d;

  assign cnt     = cnt_q;
  assign at_last = (cnt_q == LAST_V);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = {{(SEL_W-1){1'b0}}, 1'b1};
    end else if (inc) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tdm_demux16.sv
// TDM receive demux: frame-sync lock FSM, lane steering, frame capture and error flag.
module tdm_demux16
  import tdm_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [N_CH-1:0]  y,
  output logic [N_CH-1:0]  frame_out,
  output logic             frame_valid,
  output logic [SEL_W-1:0] ch_sel,
  output logic             locked,
  output logic             sync_err
);

  state_e           state_q, state_d;
  logic [N_CH-1:0]  shadow_q, shadow_d;
  logic [N_CH-1:0]  y_q, y_d;
  logic [N_CH-1:0]  frame_out_q, frame_out_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;
  logic             inc, load1, clr;
  logic [SEL_W-1:0] cnt;
  logic             at_last;

  tdm_ch_counter #(
    .SEL_W  (SEL_W),
    .LAST_P (N_CH - 1)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (inc),
    .load1   (load1),
    .clr     (clr),
    .cnt     (cnt),
    .at_last (at_last)
  );

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    y_d           = y_q;
    frame_out_d   = frame_out_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    inc           = 1'b0;
    load1         = 1'b0;
    clr           = 1'b0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            shadow_d[0] = din;
            y_d[0]      = din;
            load1       = 1'b1;
            state_d     = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync && (cnt != '0)) begin
            // Early sync: drop the partial frame and realign on this beat.
            sync_err_d  = 1'b1;
            shadow_d[0] = din;
            y_d[0]      = din;
            load1       = 1'b1;
          end else if (!frame_sync && (cnt == '0)) begin
            sync_err_d = 1'b1;
            clr        = 1'b1;
            state_d    = HUNT;
          end else begin
            shadow_d[cnt] = din;
            y_d[cnt]      = din;
            inc           = 1'b1;
            if (at_last) begin
              frame_out_d   = {din, shadow_q[N_CH-2:0]};
              frame_valid_d = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      shadow_q      <= '0;
      y_q           <= '0;
      frame_out_q   <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      y_q           <= y_d;
      frame_out_q   <= frame_out_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign y           = y_q;
  assign frame_out   = frame_out_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign ch_sel      = cnt;
  assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux16.sv
// Directed self-checking bench for tdm_demux16.
module tb_tdm_demux16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        frame_sync = 1'b0;
  logic [15:0] y;
  logic [15:0] frame_out;
  logic        frame_valid;
  logic [3:0]  ch_sel;
  logic        locked;
  logic        sync_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] y_exp  = '0;
  logic [15:0] fo_exp = '0;

  tdm_demux16 #(.N_CH(16), .SEL_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .y           (y),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .ch_sel      (ch_sel),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      din_valid = 1'b0;
      din       = 1'b1;
      frame_sync = 1'b1;
      @(posedge clk); #1;
      check_eq("gap_fv", frame_valid, 1'b0);
      check_eq("gap_err", sync_err, 1'b0);
      check_eq("gap_y", y, y_exp);
    end
  endtask

  task automatic beat(input logic d, input logic s);
    @(negedge clk);
    din        = d;
    frame_sync = s;
    din_valid  = 1'b1;
    @(posedge clk); #1;
  endtask

  // Sends beats 0..n-1 of v LSB-first, sync on beat 0, optional gap after each beat.
  task automatic send_beats(input logic [15:0] v, input int unsigned n,
                            input int unsigned gap, input logic err0);
    for (int unsigned i = 0; i < n; i++) begin
      beat(v[i], i == 0);
      y_exp[i] = v[i];
      if (i == 15) fo_exp = v;
      check_eq("locked", locked, 1'b1);
      check_eq("y", y, y_exp);
      check_eq("ch_sel", ch_sel, (i + 1) % 16);
      check_eq("frame_valid", frame_valid, i == 15);
      check_eq("frame_out", frame_out, fo_exp);
      check_eq("sync_err", sync_err, (i == 0) && err0);
      if (gap != 0) idle(gap);
    end
  endtask

  task automatic do_reset(input int unsigned n);
    @(negedge clk);
    rst       = 1'b1;
    din_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    y_exp  = '0;
    fo_exp = '0;
    check_eq("rst_y", y, 16'h0);
    check_eq("rst_frame_out", frame_out, 16'h0);
    check_eq("rst_fv", frame_valid, 1'b0);
    check_eq("rst_err", sync_err, 1'b0);
    check_eq("rst_locked", locked, 1'b0);
    check_eq("rst_ch_sel", ch_sel, 4'h0);
    rst = 1'b0;
  endtask

  initial begin
    do_reset(2);

    // Basic frame
    send_beats(16'hA5C3, 16, 0, 1'b0);
    idle(1);

    // Gapped stream
    send_beats(16'h8001, 16, 3, 1'b0);

    // Early sync: 5 beats of a frame, then a fresh frame
    send_beats(16'h0F0F, 5, 0, 1'b0);
    send_beats(16'h00FF, 16, 0, 1'b1);

    // Missing sync after complete frame
    beat(1'b1, 1'b0);
    check_eq("miss_err", sync_err, 1'b1);
    check_eq("miss_locked", locked, 1'b0);
    check_eq("miss_y", y, y_exp);
    check_eq("miss_ch_sel", ch_sel, 4'h0);
    check_eq("miss_fv", frame_valid, 1'b0);
    for (int unsigned k = 0; k < 3; k++) begin
      beat(1'b1, 1'b0);
      check_eq("hunt_y", y, y_exp);
      check_eq("hunt_locked", locked, 1'b0);
      check_eq("hunt_err", sync_err, 1'b0);
      check_eq("hunt_ch_sel", ch_sel, 4'h0);
    end
    send_beats(16'h3C5A, 16, 0, 1'b0);

    // Reset mid-frame
    send_beats(16'hFFFF, 9, 0, 1'b0);
    do_reset(1);
    idle(1);
    send_beats(16'h1234, 16, 0, 1'b0);

    // Back-to-back frames
    send_beats(16'h5555, 16, 0, 1'b0);
    send_beats(16'hAAAA, 16, 0, 1'b0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
